mem_rr_arbiter: RTL and testbench

//  Shares the single memory port between N_ACCESSORS requesters (core, cache, ...).

---
 rtl/mem_rr_arbiter_pkg.sv | 17 +
 rtl/mem_rr_arbiter_picker.sv | 40 ++++
 rtl/mem_rr_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_rr_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_rr_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM state encoding and the
// accessor write-size codes used on acc_write_size_i / mem_write_size_o.
package mem_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } arb_state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int ADDR_W = 32;

endpackage

// File: rtl/mem_rr_arbiter_picker.sv
// Combinational round-robin picker: rotates the request vector so the slot
// after last_grant sits at bit 0, priority-encodes, then rotates the index back.
module rr_picker
    import mem_rr_arbiter_pkg::*;
#(
    parameter int  N  = 2,
    localparam int GW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [GW-1:0] last_grant_i,
    output logic          any_o,
    output logic [GW-1:0] grant_o
);

    logic [GW-1:0]  start;
    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   rot;
    logic [GW-1:0]  pe;
    logic [GW:0]    sum;

    always_comb begin
        start   = (last_grant_i == GW'(N - 1)) ? '0 : last_grant_i + 1'b1;
        req_dbl = {req_i, req_i};
        rot     = req_dbl[start +: N];
        pe      = '0;
        // Scan downward so the lowest set bit (closest to start) is kept.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pe = GW'(i);
            end
        end
        sum = {1'b0, pe} + {1'b0, start};
        if (sum >= (GW + 1)'(N)) begin
            sum = sum - (GW + 1)'(N);
        end
        grant_o = sum[GW-1:0];
        any_o   = |req_i;
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one memory port between N accessors. Latches the
// winning request, holds it on mem until acknowledged, then pulses done/err back.
module mem_rr_arbiter
    import mem_rr_arbiter_pkg::*;
#(
    parameter int  BITSIZE     = 32,
    parameter int  N_ACCESSORS = 2,
    parameter int  TIMEOUT     = 256,
    localparam int GW          = $clog2(N_ACCESSORS)
) (
    input  logic                           clk,
    input  logic                           resetn_i,
    input  logic [ADDR_W*N_ACCESSORS-1:0]  acc_address_i,
    input  logic [N_ACCESSORS-1:0]         acc_write_i,
    input  logic [2*N_ACCESSORS-1:0]       acc_write_size_i,
    input  logic [N_ACCESSORS-1:0]         acc_read_i,
    input  logic [N_ACCESSORS*BITSIZE-1:0] acc_data_i,
    output logic [N_ACCESSORS*BITSIZE-1:0] acc_data_o,
    output logic [N_ACCESSORS-1:0]         acc_done_o,
    output logic [N_ACCESSORS-1:0]         acc_err_o,
    output logic [ADDR_W-1:0]              mem_addr_o,
    output logic [BITSIZE-1:0]             mem_data_o,
    output logic                           mem_write_o,
    output logic [1:0]                     mem_write_size_o,
    output logic                           mem_valid_o,
    input  logic                           mem_valid_i,
    input  logic [BITSIZE-1:0]             mem_data_i,
    output logic                           busy_o,
    output logic [GW-1:0]                  grant_o,
    output arb_state_t                     dbg_state_o
);

    localparam int N  = N_ACCESSORS;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_t         state_q, state_d;
    logic [GW-1:0]      grant_q, grant_d;
    logic [GW-1:0]      last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [BITSIZE-1:0] wdata_q, wdata_d;
    logic               write_q, write_d;
    logic [1:0]         size_q, size_d;
    logic               valid_q, valid_d;
    logic [N-1:0]       done_q, done_d;
    logic [N-1:0]       err_q, err_d;
    logic [N*BITSIZE-1:0] rdata_q, rdata_d;
    logic [CW-1:0]      wdog_q, wdog_d;

    logic [N-1:0]       req;
    logic               pick_any;
    logic [GW-1:0]      pick_idx;
    logic               timed_out;

    assign req = acc_read_i | acc_write_i;

    rr_picker #(
        .N (N)
    ) u_picker (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .any_o        (pick_any),
        .grant_o      (pick_idx)
    );

    assign timed_out = (TIMEOUT != 0) && (wdog_q == CW'(TIMEOUT));

    // Handshake: mem_valid_o is a level held from grant until the first cycle
    // mem_valid_i is sampled high; that cycle acknowledges (and, for reads,
    // carries data). mem_valid_o then drops for at least the DONE cycle.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        size_d       = size_q;
        valid_d      = valid_q;
        rdata_d      = rdata_q;
        wdog_d       = wdog_q;
        done_d       = '0;
        err_d        = '0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    addr_d  = acc_address_i[pick_idx*ADDR_W +: ADDR_W];
                    wdata_d = acc_data_i[pick_idx*BITSIZE +: BITSIZE];
                    write_d = acc_write_i[pick_idx];
                    size_d  = acc_write_size_i[pick_idx*2 +: 2];
                    wdog_d  = '0;
                    valid_d = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_valid_i) begin
                    if (!write_q) begin
                        rdata_d[grant_q*BITSIZE +: BITSIZE] = mem_data_i;
                    end
                    done_d[grant_q] = 1'b1;
                    valid_d         = 1'b0;
                    state_d         = DONE;
                end else if (timed_out) begin
                    done_d[grant_q] = 1'b1;
                    err_d[grant_q]  = 1'b1;
                    valid_d         = 1'b0;
                    state_d         = DONE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            DONE: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(N - 1);
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            size_q       <= '0;
            valid_q      <= 1'b0;
            done_q       <= '0;
            err_q        <= '0;
            rdata_q      <= '0;
            wdog_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
            size_q       <= size_d;
            valid_q      <= valid_d;
            done_q       <= done_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            wdog_q       <= wdog_d;
        end
    end

    assign acc_data_o       = rdata_q;
    assign acc_done_o       = done_q;
    assign acc_err_o        = err_q;
    assign mem_addr_o       = addr_q;
    assign mem_data_o       = wdata_q;
    assign mem_write_o      = write_q;
    assign mem_write_size_o = size_q;
    assign mem_valid_o      = valid_q;
    assign busy_o           = (state_q != IDLE);
    assign grant_o          = grant_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Self-checking bench for mem_rr_arbiter: a table of single transactions plus
// hand-written contention, timeout, withdrawal and async-reset sequences.
module tb_mem_rr_arbiter;
    import mem_rr_arbiter_pkg::*;

    localparam int W  = 32;
    localparam int N  = 2;
    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             resetn;
    logic [32*N-1:0]  acc_address;
    logic [N-1:0]     acc_write;
    logic [2*N-1:0]   acc_size;
    logic [N-1:0]     acc_read;
    logic [N*W-1:0]   acc_wdata;
    logic [N*W-1:0]   acc_data_o;
    logic [N-1:0]     acc_done;
    logic [N-1:0]     acc_err;
    logic [31:0]      mem_addr;
    logic [W-1:0]     mem_data;
    logic             mem_write;
    logic [1:0]       mem_size;
    logic             mem_valid_o;
    logic             mem_valid_i;
    logic [W-1:0]     mem_rdata;
    logic             busy;
    logic             grant;
    arb_state_t       dbg_state;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic [63:0]  exp_data;

    typedef struct {
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [3:0]  size;
        int          lat;
        logic [31:0] mdata;
        int          exp_g;
        logic        exp_w;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [1:0]  exp_size;
        logic [63:0] exp_acc;
    } vec_t;

    vec_t vecs[7];

    mem_rr_arbiter #(
        .BITSIZE     (W),
        .N_ACCESSORS (N),
        .TIMEOUT     (TO)
    ) dut (
        .clk              (clk),
        .resetn_i         (resetn),
        .acc_address_i    (acc_address),
        .acc_write_i      (acc_write),
        .acc_write_size_i (acc_size),
        .acc_read_i       (acc_read),
        .acc_data_i       (acc_wdata),
        .acc_data_o       (acc_data_o),
        .acc_done_o       (acc_done),
        .acc_err_o        (acc_err),
        .mem_addr_o       (mem_addr),
        .mem_data_o       (mem_data),
        .mem_write_o      (mem_write),
        .mem_write_size_o (mem_size),
        .mem_valid_o      (mem_valid_o),
        .mem_valid_i      (mem_valid_i),
        .mem_data_i       (mem_rdata),
        .busy_o           (busy),
        .grant_o          (grant),
        .dbg_state_o      (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete in time");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        acc_read    = '0;
        acc_write   = '0;
        acc_address = '0;
        acc_wdata   = '0;
        acc_size    = '0;
        mem_valid_i = 1'b0;
        mem_rdata   = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        @(negedge clk);
    endtask

    // Entered at a negedge in IDLE with requests already driven; returns at
    // the negedge of the following IDLE cycle.
    task automatic do_txn(input string tag, input int exp_g, input logic exp_w,
                          input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                          input logic [1:0] exp_size, input int lat,
                          input logic [31:0] mdata, input logic [63:0] exp_acc,
                          input logic [1:0] drop_mask);
        next_cycle();
        check({tag, ".valid"}, 64'(mem_valid_o), 64'd1);
        check({tag, ".grant"}, 64'(grant), 64'(exp_g));
        check({tag, ".addr"}, 64'(mem_addr), 64'(exp_addr));
        check({tag, ".write"}, 64'(mem_write), 64'(exp_w));
        check({tag, ".size"}, 64'(mem_size), 64'(exp_size));
        check({tag, ".wdata"}, 64'(mem_data), 64'(exp_wdata));
        check({tag, ".busy"}, 64'(busy), 64'd1);
        for (int k = 0; k < lat; k++) begin
            next_cycle();
            check({tag, ".hold_valid"}, 64'(mem_valid_o), 64'd1);
            check({tag, ".early_done"}, 64'(acc_done), 64'd0);
            check({tag, ".hold_addr"}, 64'(mem_addr), 64'(exp_addr));
        end
        mem_valid_i = 1'b1;
        mem_rdata   = mdata;
        @(posedge clk);
        #1;
        mem_valid_i = 1'b0;
        mem_rdata   = '0;
        @(negedge clk);
        check({tag, ".done"}, 64'(acc_done), (exp_g == 0) ? 64'd1 : 64'd2);
        check({tag, ".err"}, 64'(acc_err), 64'd0);
        check({tag, ".valid_low"}, 64'(mem_valid_o), 64'd0);
        check({tag, ".acc_data"}, acc_data_o, exp_acc);
        @(posedge clk);
        #1;
        acc_read  = acc_read & ~drop_mask;
        acc_write = acc_write & ~drop_mask;
        @(negedge clk);
        check({tag, ".done_once"}, 64'(acc_done), 64'd0);
        check({tag, ".idle"}, 64'(busy), 64'd0);
        check({tag, ".last_grant"}, 64'(grant), 64'(exp_g));
    endtask

    initial begin
        logic [31:0] cd[4];
        logic [W-1:0] g;
        logic        got;
        int          cyc;

        vecs[0] = '{2'b01, 2'b00, {32'h0, 32'h10}, 64'h0, 4'b0010, 2, 32'hDEADBEEF,
                    0, 1'b0, 32'h10, 32'h0, 2'b10, 64'h0000_0000_DEAD_BEEF};
        vecs[1] = '{2'b10, 2'b10, {32'h200, 32'h0}, {32'h12345678, 32'h0}, 4'b1000, 0, 32'hBAD0BAD0,
                    1, 1'b1, 32'h200, 32'h12345678, 2'b10, 64'h0000_0000_DEAD_BEEF};
        vecs[2] = '{2'b10, 2'b00, {32'h44, 32'h0}, 64'h0, 4'b0100, 1, 32'hCAFEF00D,
                    1, 1'b0, 32'h44, 32'h0, 2'b01, 64'hCAFE_F00D_DEAD_BEEF};
        vecs[3] = '{2'b11, 2'b00, {32'h104, 32'h100}, 64'h0, 4'b1010, 3, 32'h0BADF00D,
                    0, 1'b0, 32'h100, 32'h0, 2'b10, 64'hCAFE_F00D_0BAD_F00D};
        vecs[4] = '{2'b10, 2'b00, {32'h104, 32'h0}, 64'h0, 4'b1000, 0, 32'h11112222,
                    1, 1'b0, 32'h104, 32'h0, 2'b10, 64'h1111_2222_0BAD_F00D};
        vecs[5] = '{2'b00, 2'b01, {32'h0, 32'h3}, {32'h0, 32'hAA}, 4'b0000, 1, 32'hFFFFFFFF,
                    0, 1'b1, 32'h3, 32'hAA, SZ_BYTE, 64'h1111_2222_0BAD_F00D};
        vecs[6] = '{2'b00, 2'b11, {32'hC, 32'h8}, {32'h66, 32'h55}, 4'b1001, 0, 32'hEEEEEEEE,
                    1, 1'b1, 32'hC, 32'h66, SZ_WORD, 64'h1111_2222_0BAD_F00D};

        resetn = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.valid", 64'(mem_valid_o), 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.done", 64'(acc_done), 64'd0);
        check("rst.err", 64'(acc_err), 64'd0);
        check("rst.acc_data", acc_data_o, 64'd0);
        check("rst.grant", 64'(grant), 64'd0);
        check("rst.mem_addr", 64'(mem_addr), 64'd0);
        check("rst.mem_data", 64'(mem_data), 64'd0);
        check("rst.mem_write", 64'(mem_write), 64'd0);
        check("rst.mem_size", 64'(mem_size), 64'd0);
        check("rst.state", 64'(dbg_state), 64'(IDLE));
        resetn = 1'b1;

        next_cycle();
        check("idle.no_req", 64'(busy), 64'd0);

        for (int i = 0; i < 7; i++) begin
            acc_read    = vecs[i].rd;
            acc_write   = vecs[i].wr;
            acc_address = vecs[i].addr;
            acc_wdata   = vecs[i].wdata;
            acc_size    = vecs[i].size;
            do_txn($sformatf("vec%0d", i), vecs[i].exp_g, vecs[i].exp_w, vecs[i].exp_addr,
                   vecs[i].exp_wdata, vecs[i].exp_size, vecs[i].lat, vecs[i].mdata,
                   vecs[i].exp_acc, (vecs[i].exp_g == 0) ? 2'b01 : 2'b10);
        end
        exp_data = vecs[6].exp_acc;

        // Contention: both accessors hold read requests across four transactions.
        clear_inputs();
        acc_read    = 2'b11;
        acc_address = {32'h2000, 32'h1000};
        acc_size    = 4'b1010;
        cd[0] = 32'hA0A0A0A0;
        cd[1] = 32'hB1B1B1B1;
        cd[2] = 32'hC2C2C2C2;
        cd[3] = 32'hD3D3D3D3;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        for (int i = 0; i < 4; i++) begin
            g = exp_q.pop_front();
            exp_data[g[0]*32 +: 32] = cd[i];
            do_txn($sformatf("cont%0d", i), int'(g), 1'b0, g[0] ? 32'h2000 : 32'h1000,
                   32'h0, 2'b10, i % 2, cd[i], exp_data, (i == 3) ? 2'b11 : 2'b00);
        end

        // Timeout: mem never answers.
        clear_inputs();
        acc_read    = 2'b01;
        acc_address = {32'h0, 32'h70};
        acc_size    = 4'b0010;
        next_cycle();
        check("to.valid", 64'(mem_valid_o), 64'd1);
        check("to.grant", 64'(grant), 64'd0);
        got = 1'b0;
        cyc = 0;
        for (int k = 1; k <= 20 && !got; k++) begin
            next_cycle();
            if (acc_done != 2'b00) begin
                got = 1'b1;
                cyc = k;
            end
        end
        check("to.latency", 64'(cyc), 64'd9);
        check("to.done", 64'(acc_done), 64'd1);
        check("to.err", 64'(acc_err), 64'd1);
        check("to.acc_data", acc_data_o, exp_data);
        check("to.valid_low", 64'(mem_valid_o), 64'd0);
        @(posedge clk);
        #1;
        acc_read = 2'b00;
        @(negedge clk);
        check("to.err_once", 64'(acc_err), 64'd0);
        check("to.idle", 64'(busy), 64'd0);
        acc_read    = 2'b10;
        acc_address = {32'h74, 32'h0};
        acc_size    = 4'b1000;
        exp_data[63:32] = 32'h77778888;
        do_txn("to.next", 1, 1'b0, 32'h74, 32'h0, 2'b10, 0, 32'h77778888, exp_data, 2'b10);

        // Withdrawal: acc0 drops its request while its read is outstanding.
        clear_inputs();
        acc_read    = 2'b01;
        acc_address = {32'h0, 32'h90};
        acc_size    = 4'b0010;
        next_cycle();
        check("wd.grant", 64'(grant), 64'd0);
        check("wd.valid", 64'(mem_valid_o), 64'd1);
        acc_read    = 2'b10;
        acc_address = {32'h94, 32'h0};
        acc_size    = 4'b1000;
        next_cycle();
        check("wd.hold_valid", 64'(mem_valid_o), 64'd1);
        check("wd.hold_addr", 64'(mem_addr), 64'h90);
        check("wd.hold_grant", 64'(grant), 64'd0);
        check("wd.early_done", 64'(acc_done), 64'd0);
        mem_valid_i = 1'b1;
        mem_rdata   = 32'h99990000;
        @(posedge clk);
        #1;
        mem_valid_i = 1'b0;
        mem_rdata   = '0;
        @(negedge clk);
        exp_data[31:0] = 32'h99990000;
        check("wd.done", 64'(acc_done), 64'd1);
        check("wd.acc_data", acc_data_o, exp_data);
        check("wd.valid_low", 64'(mem_valid_o), 64'd0);
        next_cycle();
        check("wd.gap_valid", 64'(mem_valid_o), 64'd0);
        check("wd.gap_done", 64'(acc_done), 64'd0);
        exp_data[63:32] = 32'h12121212;
        do_txn("wd.next", 1, 1'b0, 32'h94, 32'h0, 2'b10, 0, 32'h12121212, exp_data, 2'b10);

        // Asynchronous reset while a read is outstanding.
        clear_inputs();
        acc_read    = 2'b10;
        acc_address = {32'h98, 32'h0};
        acc_size    = 4'b1000;
        next_cycle();
        check("rw.grant", 64'(grant), 64'd1);
        next_cycle();
        check("rw.valid", 64'(mem_valid_o), 64'd1);
        resetn = 1'b0;
        #1;
        check("rw.valid_clr", 64'(mem_valid_o), 64'd0);
        check("rw.busy_clr", 64'(busy), 64'd0);
        check("rw.grant_clr", 64'(grant), 64'd0);
        check("rw.addr_clr", 64'(mem_addr), 64'd0);
        check("rw.data_clr", acc_data_o, 64'd0);
        check("rw.state_clr", 64'(dbg_state), 64'(IDLE));
        acc_read    = 2'b11;
        acc_address = {32'h2000, 32'h1000};
        acc_size    = 4'b1010;
        next_cycle();
        check("rw.no_done", 64'(acc_done), 64'd0);
        check("rw.held", 64'(busy), 64'd0);
        resetn = 1'b1;
        exp_data = 64'h0000_0000_5A5A_5A5A;
        do_txn("rw.after", 0, 1'b0, 32'h1000, 32'h0, 2'b10, 1, 32'h5A5A5A5A, exp_data, 2'b11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
